// File: rtl/atm_keypad_pin_entry.sv
// rtl/atm_keypad_pin_entry.sv - keypad edge detect and BCD PIN collector with inactivity timeout
module atm_keypad_pin_entry #(
    parameter int P_WIDTH = 16,
    parameter int T_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pass_en,
    input  logic [T_WIDTH-1:0] threshold,
    input  logic               button_0,
    input  logic               button_1,
    input  logic               button_2,
    input  logic               button_3,
    input  logic               button_4,
    input  logic               button_5,
    input  logic               button_6,
    input  logic               button_7,
    input  logic               button_8,
    input  logic               button_9,
    input  logic               enter_button,
    input  logic               cancel_button,
    output logic [P_WIDTH-1:0] in_password,
    output logic [2:0]         digit_count,
    output logic               password_ready,
    output logic               entry_timeout,
    output logic               entry_cancel,
    output logic               key_error
);
    localparam int DIGITS = P_WIDTH / 4;

    typedef enum logic [1:0] {IDLE, COLLECT, FULL} state_t;

    state_t             state, state_nxt;
    logic [9:0]         digit_raw, digit_prev, digit_ev;
    logic               enter_prev, enter_ev, cancel_prev, cancel_ev, en_prev;
    logic [T_WIDTH-1:0] counter, counter_nxt, counter_inc;
    logic [P_WIDTH-1:0] pw_nxt;
    logic [2:0]         cnt_nxt;
    logic               ready_nxt, timeout_nxt, cancel_nxt, kerr_nxt;
    logic [3:0]         n_digits, digit_val;
    logic               en_rise, timer_hit;

    assign digit_raw = {button_9, button_8, button_7, button_6, button_5,
                        button_4, button_3, button_2, button_1, button_0};

    // Events are registered so that every key decision sees a clean one-cycle strobe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_prev  <= '0;
            digit_ev    <= '0;
            enter_prev  <= 1'b0;
            enter_ev    <= 1'b0;
            cancel_prev <= 1'b0;
            cancel_ev   <= 1'b0;
            en_prev     <= 1'b0;
        end else begin
            digit_prev  <= digit_raw;
            digit_ev    <= digit_raw & ~digit_prev;
            enter_prev  <= enter_button;
            enter_ev    <= enter_button & ~enter_prev;
            cancel_prev <= cancel_button;
            cancel_ev   <= cancel_button & ~cancel_prev;
            en_prev     <= pass_en;
        end
    end

    always_comb begin
        n_digits  = '0;
        digit_val = '0;
        for (int i = 0; i < 10; i++) begin
            if (digit_ev[i]) begin
                n_digits  = n_digits + 4'd1;
                digit_val = 4'(i);
            end
        end
    end

    // The counter holds completed idle cycles; the current one is counted via counter_inc.
    assign en_rise     = pass_en & ~en_prev;
    assign counter_inc = counter + 1'b1;
    assign timer_hit   = (threshold != '0) && (counter_inc == threshold);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en_rise) state_nxt = COLLECT;
            COLLECT, FULL: begin
                if (!pass_en || cancel_ev || timer_hit)
                    state_nxt = IDLE;
                else if (enter_ev) begin
                    if (state == FULL) state_nxt = IDLE;
                end else if (state == COLLECT && n_digits == 4'd1 &&
                             digit_count == 3'(DIGITS - 1))
                    state_nxt = FULL;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pw_nxt      = in_password;
        cnt_nxt     = digit_count;
        counter_nxt = counter;
        ready_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        cancel_nxt  = 1'b0;
        kerr_nxt    = 1'b0;
        if (state == IDLE) begin
            if (en_rise) begin
                pw_nxt      = '0;
                cnt_nxt     = '0;
                counter_nxt = '0;
            end
        end else if (pass_en) begin
            counter_nxt = counter_inc;
            if (cancel_ev) begin
                cancel_nxt = 1'b1;
                pw_nxt     = '0;
                cnt_nxt    = '0;
            end else if (timer_hit) begin
                timeout_nxt = 1'b1;
                pw_nxt      = '0;
                cnt_nxt     = '0;
            end else if (enter_ev) begin
                counter_nxt = '0;
                if (state == FULL) ready_nxt = 1'b1;
                else               kerr_nxt  = 1'b1;
            end else if (n_digits != 4'd0) begin
                counter_nxt = '0;
                if (state == FULL || n_digits != 4'd1) begin
                    kerr_nxt = 1'b1;
                end else begin
                    pw_nxt  = {in_password[P_WIDTH-5:0], digit_val};
                    cnt_nxt = digit_count + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_password    <= '0;
            digit_count    <= '0;
            counter        <= '0;
            password_ready <= 1'b0;
            entry_timeout  <= 1'b0;
            entry_cancel   <= 1'b0;
            key_error      <= 1'b0;
        end else begin
            in_password    <= pw_nxt;
            digit_count    <= cnt_nxt;
            counter        <= counter_nxt;
            password_ready <= ready_nxt;
            entry_timeout  <= timeout_nxt;
            entry_cancel   <= cancel_nxt;
            key_error      <= kerr_nxt;
        end
    end
endmodule

// File: tb/tb_atm_keypad_pin_entry.sv
// tb/tb_atm_keypad_pin_entry.sv - directed and randomized checks against a queue-based PIN model
module tb_atm_keypad_pin_entry;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pass_en = 1'b0;
    logic [31:0] threshold = '0;
    logic [9:0]  btn = '0;
    logic        enter_b = 1'b0;
    logic        cancel_b = 1'b0;
    logic [15:0] in_password;
    logic [2:0]  digit_count;
    logic        password_ready, entry_timeout, entry_cancel, key_error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_seen = 0;
    int kerr_seen = 0;
    int cancel_seen = 0;
    int timeout_seen = 0;

    // Reference model: PIN kept as a queue of digits, activity as an idle-cycle count.
    logic [11:0] m_prev, m_ev;
    bit          m_en_prev, m_active;
    int          m_idle;
    int          q[$];
    bit          e_ready, e_timeout, e_cancel, e_kerr;

    always #5 clk = ~clk;

    atm_keypad_pin_entry #(.P_WIDTH(16), .T_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .pass_en(pass_en), .threshold(threshold),
        .button_0(btn[0]), .button_1(btn[1]), .button_2(btn[2]), .button_3(btn[3]),
        .button_4(btn[4]), .button_5(btn[5]), .button_6(btn[6]), .button_7(btn[7]),
        .button_8(btn[8]), .button_9(btn[9]),
        .enter_button(enter_b), .cancel_button(cancel_b),
        .in_password(in_password), .digit_count(digit_count),
        .password_ready(password_ready), .entry_timeout(entry_timeout),
        .entry_cancel(entry_cancel), .key_error(key_error)
    );

    function automatic logic [15:0] exp_pw();
        logic [15:0] pw = '0;
        foreach (q[i]) pw = {pw[11:0], 4'(q[i])};
        return pw;
    endfunction

    function automatic void model_reset();
        m_prev = '0; m_ev = '0; m_en_prev = 0; m_active = 0; m_idle = 0;
        q.delete();
        e_ready = 0; e_timeout = 0; e_cancel = 0; e_kerr = 0;
    endfunction

    function automatic void model_step();
        logic [11:0] raw, ev;
        int nd, d;
        if (!rst) begin
            model_reset();
            return;
        end
        raw = {cancel_b, enter_b, btn};
        ev = m_ev;
        m_ev = raw & ~m_prev;
        m_prev = raw;
        e_ready = 0; e_timeout = 0; e_cancel = 0; e_kerr = 0;
        nd = $countones(ev[9:0]);
        d = 0;
        for (int i = 0; i < 10; i++) if (ev[i]) d = i;
        if (!m_active) begin
            if (pass_en && !m_en_prev) begin
                m_active = 1; q.delete(); m_idle = 0;
            end
        end else if (!pass_en) begin
            m_active = 0;
        end else if (ev[11]) begin
            e_cancel = 1; q.delete(); m_active = 0;
        end else if (threshold != 0 && m_idle + 1 == int'(threshold)) begin
            e_timeout = 1; q.delete(); m_active = 0;
        end else begin
            m_idle++;
            if (ev[10]) begin
                m_idle = 0;
                if (q.size() == 4) begin e_ready = 1; m_active = 0; end
                else e_kerr = 1;
            end else if (nd > 0) begin
                m_idle = 0;
                if (q.size() == 4 || nd > 1) e_kerr = 1;
                else q.push_back(d);
            end
        end
        m_en_prev = pass_en;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("in_password", 32'(in_password), 32'(exp_pw()));
        chk("digit_count", 32'(digit_count), 32'(q.size()));
        chk("password_ready", 32'(password_ready), 32'(e_ready));
        chk("entry_timeout", 32'(entry_timeout), 32'(e_timeout));
        chk("entry_cancel", 32'(entry_cancel), 32'(e_cancel));
        chk("key_error", 32'(key_error), 32'(e_kerr));
        chk("pulse_excl", 32'($onehot0({password_ready, entry_timeout, entry_cancel})), 32'd1);
        chk("kerr_coincide", 32'(key_error & (password_ready | entry_cancel)), 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        if (password_ready) ready_seen++;
        if (key_error) kerr_seen++;
        if (entry_cancel) cancel_seen++;
        if (entry_timeout) timeout_seen++;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_digit(input int d);
        btn[d] = 1'b1; tick(); btn = '0; ticks(2);
    endtask

    task automatic press_enter();
        enter_b = 1'b1; tick(); enter_b = 1'b0; ticks(2);
    endtask

    task automatic rearm();
        pass_en = 1'b0; tick(); pass_en = 1'b1; ticks(2);
    endtask

    initial begin
        int t_vis, t_to, r;
        model_reset();
        ticks(2);
        chk("reset_pw", 32'(in_password), 32'd0);
        chk("reset_cnt", 32'(digit_count), 32'd0);
        rst = 1'b1;
        tick();

        // basic entry
        pass_en = 1'b1; ticks(2);
        press_digit(1); press_digit(2); press_digit(3); press_digit(4);
        chk("basic_pw", 32'(in_password), 32'h1234);
        chk("basic_cnt", 32'(digit_count), 32'd4);
        ready_seen = 0;
        press_enter(); ticks(3);
        chk("basic_ready_once", 32'(ready_seen), 32'd1);
        chk("basic_pw_hold", 32'(in_password), 32'h1234);

        // held key then early enter
        rearm();
        kerr_seen = 0; ready_seen = 0;
        btn[7] = 1'b1; ticks(5); btn = '0; ticks(2);
        press_enter();
        chk("held_pw", 32'(in_password), 32'h0007);
        chk("held_cnt", 32'(digit_count), 32'd1);
        chk("held_kerr", 32'(kerr_seen), 32'd1);
        chk("held_noready", 32'(ready_seen), 32'd0);

        // overflow on a fifth digit
        rearm();
        kerr_seen = 0; ready_seen = 0;
        press_digit(9); press_digit(8); press_digit(7); press_digit(6); press_digit(5);
        chk("ovf_pw", 32'(in_password), 32'h9876);
        chk("ovf_kerr", 32'(kerr_seen), 32'd1);
        press_enter();
        chk("ovf_ready", 32'(ready_seen), 32'd1);

        // two digits together, then a key held across the enable rise
        rearm();
        kerr_seen = 0;
        btn[2] = 1'b1; btn[3] = 1'b1; tick(); btn = '0; ticks(2);
        chk("multi_kerr", 32'(kerr_seen), 32'd1);
        chk("multi_cnt", 32'(digit_count), 32'd0);
        pass_en = 1'b0; btn[4] = 1'b1; ticks(2);
        pass_en = 1'b1; ticks(3); btn = '0; ticks(2);
        chk("hold_rise_cnt", 32'(digit_count), 32'd0);

        // cancel beats a simultaneous digit
        rearm();
        cancel_seen = 0;
        press_digit(1); press_digit(2);
        cancel_b = 1'b1; btn[5] = 1'b1; tick(); cancel_b = 1'b0; btn = '0; ticks(2);
        chk("cancel_pulse", 32'(cancel_seen), 32'd1);
        chk("cancel_pw", 32'(in_password), 32'd0);
        press_digit(6);
        chk("cancel_ignored", 32'(digit_count), 32'd0);

        // inactivity timeout, then disabled timeout
        threshold = 32'd15;
        rearm();
        timeout_seen = 0; t_vis = -1; t_to = -1;
        btn[3] = 1'b1; tick(); btn = '0;
        for (int i = 0; i < 40 && t_to < 0; i++) begin
            tick();
            if (t_vis < 0 && digit_count == 3'd1) t_vis = cyc;
            if (entry_timeout) t_to = cyc;
        end
        chk("timeout_gap", 32'(t_to - t_vis), 32'd15);
        chk("timeout_cnt", 32'(digit_count), 32'd0);
        threshold = 32'd0;
        rearm();
        timeout_seen = 0;
        press_digit(8);
        ticks(200);
        chk("no_timeout", 32'(timeout_seen), 32'd0);

        // aborts
        rearm();
        ready_seen = 0; kerr_seen = 0; cancel_seen = 0; timeout_seen = 0;
        press_digit(4); press_digit(5); press_digit(6);
        pass_en = 1'b0; ticks(3);
        chk("drop_cnt", 32'(digit_count), 32'd3);
        chk("drop_pulses", 32'(ready_seen + kerr_seen + cancel_seen + timeout_seen), 32'd0);
        rearm();
        press_digit(2); press_digit(1);
        rst = 1'b0;
        #1;
        chk("async_rst_pw", 32'(in_password), 32'd0);
        chk("async_rst_cnt", 32'(digit_count), 32'd0);
        model_reset();
        ticks(2);
        rst = 1'b1;
        tick();

        // randomized traffic
        for (int c = 0; c < 1500; c++) begin
            if (c % 250 == 0)
                threshold = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(8, 40));
            btn = '0; enter_b = 1'b0; cancel_b = 1'b0;
            r = $urandom_range(0, 99);
            if (r < 30) btn[$urandom_range(0, 9)] = 1'b1;
            else if (r < 33) begin
                btn[$urandom_range(0, 9)] = 1'b1;
                btn[$urandom_range(0, 9)] = 1'b1;
            end
            if ($urandom_range(0, 99) < 7) enter_b = 1'b1;
            if ($urandom_range(0, 99) < 2) cancel_b = 1'b1;
            if (pass_en && $urandom_range(0, 99) < 2) pass_en = 1'b0;
            else if (!pass_en && $urandom_range(0, 99) < 30) pass_en = 1'b1;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
